// File: rtl/chdr_sample_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : chdr_sample_framer                                           |
// | Description : Packs a 32-bit sample stream into CVITA data packets with an |
// |               exact-length header; CHDR_FRAMER_TIME_EN adds a timestamp.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module chdr_sample_framer #(
    parameter int BUF_SIZE = 9,
    parameter int SPP_MAX  = 2**BUF_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] sid,
    input  logic [15:0] spp,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
`ifdef CHDR_FRAMER_TIME_EN
    ,
    input  logic [63:0] vita_time
`endif
);

    localparam int          c_DEPTH   = 2**BUF_SIZE;
    localparam logic [16:0] c_SPP_MAX = 17'(SPP_MAX);
`ifdef CHDR_FRAMER_TIME_EN
    localparam logic        c_HAS_TIME = 1'b1;
`else
    localparam logic        c_HAS_TIME = 1'b0;
`endif
    localparam logic [15:0] c_HDR_BYTES = c_HAS_TIME ? 16'd16 : 16'd8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
`ifdef CHDR_FRAMER_TIME_EN
        S_TIME    = 2'd3,
`endif
        S_PAYLOAD = 2'd2
    } state_t;

    // Payload buffer and descriptor FIFO storage
    logic [63:0]       mem [c_DEPTH];
    logic [16:0]       dn_mem  [4];
    logic              deob_mem[4];
`ifdef CHDR_FRAMER_TIME_EN
    logic [63:0]       dtime_mem[4];
    logic [63:0]       time_q;
    logic [63:0]       w_first_time;
`endif

    logic [BUF_SIZE:0] wr_ptr_q, rd_ptr_q, w_used;
    logic [16:0]       cnt_q, spp_q, w_spp_eff, w_spp_cur, w_n;
    logic [31:0]       hold_q;
    logic              w_acc, w_close, w_wr_en;
    logic [63:0]       w_wr_data;
    logic [1:0]        dwp_q, drp_q;
    logic [2:0]        dcnt_q;

    state_t            state_q, state_d;
    logic [63:0]       odata_q, odata_d;
    logic              olast_q, olast_d, ovalid_q, ovalid_d;
    logic [16:0]       rem_q, rem_d;
    logic [11:0]       seq_q;
    logic              w_hs, w_pop, w_rd_inc, w_load_hdr, w_load_pl;
    logic [1:0]        w_hidx;
    logic [11:0]       w_hseq;
    logic [16:0]       w_hn, w_hwords;
    logic [15:0]       w_hlen;
    logic [63:0]       w_hdr, w_pl;

    // ---------------- input side ----------------
    assign w_used    = wr_ptr_q - rd_ptr_q;
    assign i_tready  = ~reset & ~clear & ~w_used[BUF_SIZE] & (dcnt_q != 3'd4);
    assign w_acc     = i_tvalid & i_tready;
    assign w_spp_eff = ((spp == 16'd0) || ({1'b0, spp} > c_SPP_MAX)) ? c_SPP_MAX : {1'b0, spp};
    assign w_spp_cur = (cnt_q == 17'd0) ? w_spp_eff : spp_q;
    assign w_n       = cnt_q + 17'd1;
    assign w_close   = w_acc & ((w_n == w_spp_cur) | i_tlast);
    // A word is written on every second sample, or early when an odd packet closes
    assign w_wr_en   = w_acc & (cnt_q[0] | w_close);
    assign w_wr_data = cnt_q[0] ? {hold_q, i_tdata} : {i_tdata, 32'h0};
`ifdef CHDR_FRAMER_TIME_EN
    assign w_first_time = (cnt_q == 17'd0) ? vita_time : time_q;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q    <= '0;
            spp_q    <= '0;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            dwp_q    <= '0;
`ifdef CHDR_FRAMER_TIME_EN
            time_q   <= '0;
`endif
        end else if (w_acc) begin
            if (cnt_q == 17'd0) begin
                spp_q  <= w_spp_eff;
`ifdef CHDR_FRAMER_TIME_EN
                time_q <= vita_time;
`endif
            end
            cnt_q <= w_close ? 17'd0 : w_n;
            if (!cnt_q[0])
                hold_q <= i_tdata;
            if (w_wr_en)
                wr_ptr_q <= wr_ptr_q + {{BUF_SIZE{1'b0}}, 1'b1};
            if (w_close)
                dwp_q <= dwp_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            mem[wr_ptr_q[BUF_SIZE-1:0]] <= w_wr_data;
        if (w_close) begin
            dn_mem[dwp_q]    <= w_n;
            deob_mem[dwp_q]  <= i_tlast;
`ifdef CHDR_FRAMER_TIME_EN
            dtime_mem[dwp_q] <= w_first_time;
`endif
        end
    end

    // ---------------- output side ----------------
    assign w_hs     = ovalid_q & o_tready;
    // Back-to-back packets build the next header from the entry behind the head
    assign w_hidx   = (state_q == S_IDLE) ? drp_q : drp_q + 2'd1;
    assign w_hseq   = (state_q == S_IDLE) ? seq_q : seq_q + 12'd1;
    assign w_hn     = dn_mem[w_hidx];
    assign w_hwords = (w_hn + 17'd1) >> 1;
    assign w_hlen   = c_HDR_BYTES + {w_hn[13:0], 2'b00};
    assign w_hdr    = {2'b00, c_HAS_TIME, deob_mem[w_hidx], w_hseq, w_hlen, sid};
    assign w_pl     = mem[rd_ptr_q[BUF_SIZE-1:0]];

    always_comb begin
        state_d    = state_q;
        odata_d    = odata_q;
        olast_d    = olast_q;
        ovalid_d   = ovalid_q;
        rem_d      = rem_q;
        w_pop      = 1'b0;
        w_rd_inc   = 1'b0;
        w_load_hdr = 1'b0;
        w_load_pl  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dcnt_q != 3'd0)
                    w_load_hdr = 1'b1;
            end
            S_HDR: begin
                if (w_hs) begin
`ifdef CHDR_FRAMER_TIME_EN
                    state_d = S_TIME;
                    odata_d = dtime_mem[drp_q];
`else
                    w_load_pl = 1'b1;
`endif
                end
            end
`ifdef CHDR_FRAMER_TIME_EN
            S_TIME: begin
                if (w_hs)
                    w_load_pl = 1'b1;
            end
`endif
            S_PAYLOAD: begin
                if (w_hs) begin
                    if (olast_q) begin
                        w_pop = 1'b1;
                        if (dcnt_q >= 3'd2) begin
                            w_load_hdr = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            ovalid_d = 1'b0;
                            olast_d  = 1'b0;
                        end
                    end else begin
                        w_load_pl = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                ovalid_d = 1'b0;
                olast_d  = 1'b0;
            end
        endcase
        if (w_load_hdr) begin
            state_d  = S_HDR;
            odata_d  = w_hdr;
            olast_d  = 1'b0;
            ovalid_d = 1'b1;
            rem_d    = w_hwords;
        end
        if (w_load_pl) begin
            state_d  = S_PAYLOAD;
            odata_d  = w_pl;
            olast_d  = (rem_q == 17'd1);
            rem_d    = rem_q - 17'd1;
            w_rd_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q  <= S_IDLE;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            ovalid_q <= 1'b0;
            rem_q    <= '0;
            seq_q    <= '0;
            rd_ptr_q <= '0;
            drp_q    <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            ovalid_q <= ovalid_d;
            rem_q    <= rem_d;
            if (w_rd_inc)
                rd_ptr_q <= rd_ptr_q + {{BUF_SIZE{1'b0}}, 1'b1};
            if (w_pop) begin
                seq_q <= seq_q + 12'd1;
                drp_q <= drp_q + 2'd1;
            end
            case ({w_close, w_pop})
                2'b10:   dcnt_q <= dcnt_q + 3'd1;
                2'b01:   dcnt_q <= dcnt_q - 3'd1;
                default: dcnt_q <= dcnt_q;
            endcase
        end
    end

    assign o_tdata  = odata_q;
    assign o_tlast  = olast_q;
    assign o_tvalid = ovalid_q;

endmodule
`default_nettype wire

// File: doc/chdr_sample_framer.md
# chdr_sample_framer

- Converts a raw 32-bit sample stream into CVITA data packets.
- Sits directly upstream of an RFNoC block's stream-source port (the `str_src` / `s_cvita_data` path of NoC Shell) and feeds it complete packets.
- Buffers each packet so the header carries the exact length, sequence number, SID and EOB flag.
- Optionally inserts a timestamp.

## Interface
Parameters:
- BUF_SIZE, 9: log2 of payload buffer depth in 64-bit words.
- SPP_MAX, 2**BUF_SIZE: hard ceiling on samples per packet.

Ports:
- clk  in  1  block clock; everything is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; same effect as reset on datapath and seqnum, one-cycle pulse.
- sid  in  32  stream ID written to header bits [31:0].
- spp  in  16  samples per packet; 0 or values > SPP_MAX mean SPP_MAX.
- i_tdata  in  32  sample (e.g. sc16 I/Q).
- i_tlast  in  1  end of burst; closes the current packet early and sets EOB.
- i_tvalid  in  1  sample valid.
- i_tready  out  1  sample accept.
- o_tdata  out  64  CVITA word out.
- o_tlast  out  1  last word of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream accept.
- vita_time  in  64  time counter; present only with CHDR_FRAMER_TIME_EN.

## Operation
Input side:
- spp is sampled on the first accepted sample of each packet.
- A packet closes when the sample count reaches the sampled spp, or on the sample accepted with i_tlast.
- Sample pairs pack into one word: first sample in [63:32], second in [31:0].
- If a packet has an odd sample count, [31:0] of its final word is written as 0.
- On close, {sample count, EOB flag, time if enabled} is pushed into a 4-entry descriptor FIFO.
- i_tready=0 when any of these holds: the buffer lacks room for one more word, the descriptor FIFO is full, or the cycle is a reset or clear cycle.

Output FSM: IDLE -> HDR -> [TIME] -> PAYLOAD -> IDLE.
- IDLE -> HDR when the descriptor FIFO is non-empty.
- HDR word:
  - [63:62]=00 (data).
  - [61]=has_time.
  - [60]=EOB.
  - [59:48]=seqnum.
  - [47:32]=length in bytes = 8 + 8·has_time + 4·nsamples.
  - [31:0]=sid, sampled when the HDR word is presented.
- TIME (macro only): emits the 64-bit timestamp.
- PAYLOAD emits ceil(nsamples/2) words. o_tlast is asserted on the final one; the descriptor is popped on that beat.
- seqnum is 12 bits:
  - Increments after each packet's o_tlast handshake; wraps 4095->0.
  - 0 after reset or clear.
- Simultaneous packet close on input and pop on output in the same cycle: both take effect and the FIFO count is unchanged.
- An i_tlast sample that also fills spp closes one packet with EOB=1, not two.
- Reset or clear mid-packet:
  - Partial input packet, buffered packets and descriptors are discarded.
  - The FSM returns to IDLE.
  - o_tvalid drops in the next cycle.
  - A truncated output packet is acceptable only on reset/clear.

## Timing
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0 during the reset cycle, 1 on the following cycle.
- Input throughput is 1 sample/cycle while i_tready=1.
- Output throughput is 1 word/cycle while o_tready=1.
- Per-packet output overhead is 1 cycle (HDR), or 2 cycles with TIME.
- Latency: the HDR word shows o_tvalid no later than 2 cycles after the closing sample is accepted, provided the FSM was in IDLE.
- AXI-stream rules on o_*: while o_tvalid=1 and o_tready=0, o_tdata, o_tlast and o_tvalid hold stable. o_tvalid never depends combinationally on o_tready.
- The buffer holds at least two SPP_MAX packets, so input continues while the previous packet drains.

## Configuration
- CHDR_FRAMER_TIME_EN defined:
  - vita_time port exists.
  - vita_time is latched on each packet's first accepted sample.
  - has_time=1 and a TIME word follows HDR.
- Undefined:
  - No vita_time port.
  - has_time=0, no TIME state; length = 8 + 4·nsamples.

## Test plan
- spp=4, sid=0x0002_0010, 8 samples with o_tready=1 -> two packets, each 3 words. Headers 0x0000_0018_0002_0010 and 0x0001_0018_0002_0010.
- spp=4, 3 samples with i_tlast on the 3rd -> HDR 0x1000_0014_xxxx_xxxx. Second payload word = {s2, 32'h0}.
- 4097 packets of spp=2 -> seqnum runs 0..4095 then 0. Every length field = 0x0010.
- o_tready toggling 1-of-3 cycles during a 64-sample spp=64 stream -> output words identical to the unstalled run; no word duplicated or dropped; i_tready drops only when the buffer is full.
- clear asserted mid-packet with 2 packets queued -> o_tvalid=0 within 1 cycle. The next packet starts with seqnum 0 and contains only post-clear samples.
- TIME_EN, vita_time=0x100 at the first sample, spp=2 -> words HDR (bit61=1, len 0x0018), 0x0000_0000_0000_0100, payload.
